// File: rtl/alien_formation_ctrl.sv
// Formation origin controller for the alien march: lateral steps, edge drops, speed-up on kills.
// Optional wing-flap animation select is built when FORMATION_ANIM_EN is defined.
module alien_formation_ctrl #(
    parameter int unsigned START_X     = 135,
    parameter int unsigned START_Y     = 85,
    parameter int unsigned FORM_WIDTH  = 431,
    parameter int unsigned STEP_X      = 4,
    parameter int unsigned STEP_DOWN   = 8,
    parameter int unsigned LEFT_LIMIT  = 8,
    parameter int unsigned RIGHT_LIMIT = 632,
    parameter int unsigned BOTTOM_Y    = 360,
    parameter int unsigned INIT_PERIOD = 30,
    parameter int unsigned MIN_PERIOD  = 2
) (
    input  logic       clk_pix,
    input  logic       rst,
    input  logic [9:0] sx,
    input  logic [9:0] sy,
    input  logic       run,
    input  logic       alien_killed,
    output logic [9:0] form_x,
    output logic [8:0] form_y,
    output logic       anim_frame,
    output logic       step_pulse,
    output logic       landed
);

    typedef enum logic [2:0] {
        MARCH_R,
        MARCH_L,
        DROP_R,
        DROP_L,
        LANDED
    } state_t;

    localparam logic [9:0]  C_START_X     = 10'(START_X);
    localparam logic [8:0]  C_START_Y     = 9'(START_Y);
    localparam logic [10:0] C_FORM_WIDTH  = 11'(FORM_WIDTH);
    localparam logic [10:0] C_STEP_X      = 11'(STEP_X);
    localparam logic [9:0]  C_STEP_X10    = 10'(STEP_X);
    localparam logic [9:0]  C_STEP_DOWN   = 10'(STEP_DOWN);
    localparam logic [10:0] C_LEFT_LIMIT  = 11'(LEFT_LIMIT);
    localparam logic [10:0] C_RIGHT_LIMIT = 11'(RIGHT_LIMIT);
    localparam logic [9:0]  C_BOTTOM_Y    = 10'(BOTTOM_Y);
    localparam logic [5:0]  C_INIT_PERIOD = 6'(INIT_PERIOD);
    localparam logic [5:0]  C_MIN_PERIOD  = 6'(MIN_PERIOD);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [9:0]  r_form_x;
    logic [9:0]  w_form_x_nxt;
    logic [8:0]  r_form_y;
    logic [8:0]  w_form_y_nxt;
    logic        r_landed;
    logic        w_landed_nxt;
    logic [5:0]  r_frame_cnt;
    logic [5:0]  r_period;
    logic        r_step_pulse;

    logic        w_frame_tick;
    logic        w_count_en;
    logic        w_cnt_done;
    logic        w_step_fire;
    logic        w_right_edge;
    logic        w_left_edge;
    logic [9:0]  w_drop_y;

    assign w_frame_tick = (sx == 10'd0) && (sy == 10'd480);
    assign w_count_en   = w_frame_tick && run && (r_state != LANDED);
    // >= rather than == so a period shortened below the running count still fires next tick
    assign w_cnt_done   = ({1'b0, r_frame_cnt} + 7'd1) >= {1'b0, r_period};
    assign w_step_fire  = w_count_en && w_cnt_done;

    assign w_right_edge = ({1'b0, r_form_x} + C_FORM_WIDTH + C_STEP_X) > C_RIGHT_LIMIT;
    assign w_left_edge  = {1'b0, r_form_x} < (C_LEFT_LIMIT + C_STEP_X);
    assign w_drop_y     = {1'b0, r_form_y} + C_STEP_DOWN;

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            r_state      <= MARCH_R;
            r_form_x     <= C_START_X;
            r_form_y     <= C_START_Y;
            r_landed     <= 1'b0;
            r_frame_cnt  <= '0;
            r_period     <= C_INIT_PERIOD;
            r_step_pulse <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_form_x     <= w_form_x_nxt;
            r_form_y     <= w_form_y_nxt;
            r_landed     <= w_landed_nxt;
            r_step_pulse <= w_step_fire;
            if (w_count_en) begin
                r_frame_cnt <= w_cnt_done ? '0 : r_frame_cnt + 6'd1;
            end
            // The registered period is what the tick compares against, so a kill on the tick applies next frame
            if (alien_killed && (r_period > C_MIN_PERIOD)) begin
                r_period <= r_period - 6'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_form_x_nxt = r_form_x;
        w_form_y_nxt = r_form_y;
        w_landed_nxt = r_landed;
        if (w_step_fire) begin
            case (r_state)
                MARCH_R: begin
                    if (w_right_edge) w_state_nxt  = DROP_R;
                    else              w_form_x_nxt = r_form_x + C_STEP_X10;
                end
                MARCH_L: begin
                    if (w_left_edge) w_state_nxt  = DROP_L;
                    else             w_form_x_nxt = r_form_x - C_STEP_X10;
                end
                DROP_R, DROP_L: begin
                    w_form_y_nxt = w_drop_y[8:0];
                    if (w_drop_y >= C_BOTTOM_Y) begin
                        w_state_nxt  = LANDED;
                        w_landed_nxt = 1'b1;
                    end else begin
                        w_state_nxt = (r_state == DROP_R) ? MARCH_L : MARCH_R;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

`ifdef FORMATION_ANIM_EN
    logic r_anim;

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            r_anim <= 1'b0;
        end else if (w_step_fire) begin
            r_anim <= ~r_anim;
        end
    end

    assign anim_frame = r_anim;
`else
    assign anim_frame = 1'b0;
`endif

    assign form_x     = r_form_x;
    assign form_y     = r_form_y;
    assign step_pulse = r_step_pulse;
    assign landed     = r_landed;

endmodule
